// File: rtl/regfile_arbiter.sv
// Shares the single-port register file between host (req 0) and engine (req 1).
// Round-robin grants, host lock for atomic RMW, registered read return.
module regfile_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int Addr_Depth = 12
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [Addr_Depth-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic                  h_lock,
  output logic                  h_gnt,
  output logic                  h_rvalid,
  output logic [DATA_WIDTH-1:0] h_rdata,
  input  logic                  e_req,
  input  logic                  e_we,
  input  logic [Addr_Depth-1:0] e_addr,
  input  logic [DATA_WIDTH-1:0] e_wdata,
  output logic                  e_gnt,
  output logic                  e_rvalid,
  output logic [DATA_WIDTH-1:0] e_rdata,
  output logic [Addr_Depth-1:0] rf_address,
  output logic                  rf_en_write,
  output logic                  rf_en_read,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic [DATA_WIDTH-1:0] rf_data_out,
  input  logic                  rf_control_reg,
  output logic                  engine_run
);

  logic h_gnt_q, h_gnt_d;
  logic e_gnt_q, e_gnt_d;
  logic last_eng_q, last_eng_d;
  logic lock_q, lock_d;
  logic en_rd_q, en_rd_d;
  logic en_wr_q, en_wr_d;
  logic [Addr_Depth-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic tag1_q, tag1_d;
  logic vld2_q, vld2_d;
  logic tag2_q, tag2_d;
  logic h_rv_q, h_rv_d;
  logic e_rv_q, e_rv_d;
  logic [DATA_WIDTH-1:0] h_rd_q, h_rd_d;
  logic [DATA_WIDTH-1:0] e_rd_q, e_rd_d;
  logic run_q;
  logic h_elig, e_elig;

  always_comb begin
    h_elig = h_req & ~h_gnt_q;
    // lock releases on the same edge h_lock drops
    e_elig = e_req & ~e_gnt_q & ~(lock_q & h_lock);
    h_gnt_d = h_elig & (~e_elig | last_eng_q);
    e_gnt_d = e_elig & ~h_gnt_d;
    last_eng_d = last_eng_q;
    lock_d = h_lock & (lock_q | h_gnt_d);
    en_rd_d = 1'b0;
    en_wr_d = 1'b0;
    addr_d = addr_q;
    wdat_d = wdat_q;
    unique case (1'b1)
      h_gnt_d: begin
        last_eng_d = 1'b0;
        en_rd_d = ~h_we;
        en_wr_d = h_we;
        addr_d = h_addr;
        wdat_d = h_wdata;
      end
      e_gnt_d: begin
        last_eng_d = 1'b1;
        en_rd_d = ~e_we;
        en_wr_d = e_we;
        addr_d = e_addr;
        wdat_d = e_wdata;
      end
      default: ;
    endcase
    tag1_d = e_gnt_d;
    vld2_d = en_rd_q;
    tag2_d = tag1_q;
    // data bus is only sampled when a read is due
    h_rv_d = vld2_q & ~tag2_q;
    e_rv_d = vld2_q & tag2_q;
    h_rd_d = h_rv_d ? rf_data_out : h_rd_q;
    e_rd_d = e_rv_d ? rf_data_out : e_rd_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      h_gnt_q    <= 1'b0;
      e_gnt_q    <= 1'b0;
      last_eng_q <= 1'b1;
      lock_q     <= 1'b0;
      en_rd_q    <= 1'b0;
      en_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      tag1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      tag2_q     <= 1'b0;
      h_rv_q     <= 1'b0;
      e_rv_q     <= 1'b0;
      h_rd_q     <= '0;
      e_rd_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      h_gnt_q    <= h_gnt_d;
      e_gnt_q    <= e_gnt_d;
      last_eng_q <= last_eng_d;
      lock_q     <= lock_d;
      en_rd_q    <= en_rd_d;
      en_wr_q    <= en_wr_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      tag1_q     <= tag1_d;
      vld2_q     <= vld2_d;
      tag2_q     <= tag2_d;
      h_rv_q     <= h_rv_d;
      e_rv_q     <= e_rv_d;
      h_rd_q     <= h_rd_d;
      e_rd_q     <= e_rd_d;
      run_q      <= rf_control_reg;
    end
  end

  assign h_gnt       = h_gnt_q;
  assign e_gnt       = e_gnt_q;
  assign h_rvalid    = h_rv_q;
  assign e_rvalid    = e_rv_q;
  assign h_rdata     = h_rd_q;
  assign e_rdata     = e_rd_q;
  assign rf_address  = addr_q;
  assign rf_en_write = en_wr_q;
  assign rf_en_read  = en_rd_q;
  assign rf_data_in  = wdat_q;
  assign engine_run  = run_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: random host/engine traffic against a
// transaction-level model with a shadow memory and a read-return queue.
module tb_regfile_arbiter;

  logic        clock;
  logic        rst_n;
  logic        h_req, h_we, h_lock;
  logic [11:0] h_addr;
  logic [23:0] h_wdata;
  logic        h_gnt, h_rvalid;
  logic [23:0] h_rdata;
  logic        e_req, e_we;
  logic [11:0] e_addr;
  logic [23:0] e_wdata;
  logic        e_gnt, e_rvalid;
  logic [23:0] e_rdata;
  logic [11:0] rf_address;
  logic        rf_en_write, rf_en_read;
  logic [23:0] rf_data_in;
  logic [23:0] rf_data_out;
  logic        rf_control_reg;
  logic        engine_run;

  regfile_arbiter #(.DATA_WIDTH(24), .Addr_Depth(12)) dut (
    .clock(clock), .rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr),
    .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .rf_address(rf_address), .rf_en_write(rf_en_write),
    .rf_en_read(rf_en_read), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out), .rf_control_reg(rf_control_reg),
    .engine_run(engine_run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // register file: write at edge, read data one cycle later, Z when idle
  bit [23:0] rfm [4096];
  bit        rf_vld;
  logic [23:0] rf_dat;
  always @(posedge clock) begin
    if (rf_en_write) rfm[rf_address] <= rf_data_in;
    rf_vld <= rf_en_read;
    if (rf_en_read) rf_dat <= rfm[rf_address];
  end
  assign rf_data_out = rf_vld ? rf_dat : 'z;
  assign rf_control_reg = rfm[0][0];

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [23:0] data;
    bit          lock;
    int          gap;
  } cmd_t;

  typedef struct {
    int          due;
    bit          eng;
    logic [23:0] data;
  } rd_t;

  cmd_t hq[$];
  cmd_t eq[$];
  rd_t  pend[$];
  bit [23:0] shadow [4096];

  bit   m_hg, m_eg, m_last_eng, m_lock;
  logic [11:0] m_addr;
  logic [23:0] m_wd, m_hrd, m_erd;
  bit   h_act, e_act;
  int   h_wait, e_wait;
  int   cyc;
  int   n_tests, n_fail;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic cmd(ref cmd_t q[$], input bit we,
                     input logic [11:0] a, input logic [23:0] d,
                     input bit lk, input int gap);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d; c.lock = lk; c.gap = gap;
    q.push_back(c);
  endtask

  task automatic model_reset();
    m_hg = 0; m_eg = 0; m_last_eng = 1; m_lock = 0;
    m_addr = '0; m_wd = '0; m_hrd = '0; m_erd = '0;
    pend.delete(); hq.delete(); eq.delete();
    h_act = 0; e_act = 0; h_wait = 0; e_wait = 0;
    h_req = 0; e_req = 0; h_lock = 0;
  endtask

  task automatic check_zero(string p);
    chk({p, "_h_gnt"}, 32'(h_gnt), 0);
    chk({p, "_e_gnt"}, 32'(e_gnt), 0);
    chk({p, "_h_rvalid"}, 32'(h_rvalid), 0);
    chk({p, "_e_rvalid"}, 32'(e_rvalid), 0);
    chk({p, "_h_rdata"}, 32'(h_rdata), 0);
    chk({p, "_e_rdata"}, 32'(e_rdata), 0);
    chk({p, "_rf_addr"}, 32'(rf_address), 0);
    chk({p, "_rf_rd"}, 32'(rf_en_read), 0);
    chk({p, "_rf_wr"}, 32'(rf_en_write), 0);
    chk({p, "_rf_din"}, 32'(rf_data_in), 0);
    chk({p, "_run"}, 32'(engine_run), 0);
  endtask

  task automatic step();
    bit hr, hw, hl, er, ew, ct, he, ee, rd, wr, hv, ev;
    logic [11:0] ha, ea;
    logic [23:0] hd, ed;
    int win;
    rd_t r;
    hr = h_req; hw = h_we; hl = h_lock; ha = h_addr; hd = h_wdata;
    er = e_req; ew = e_we; ea = e_addr; ed = e_wdata;
    ct = rf_control_reg;
    @(posedge clock);
    #1;
    cyc++;
    he = hr && !m_hg;
    ee = er && !m_eg && !(m_lock && hl);
    win = -1;
    if (he && ee) win = m_last_eng ? 0 : 1;
    else if (he) win = 0;
    else if (ee) win = 1;
    m_lock = hl && (m_lock || win == 0);
    rd = 0; wr = 0;
    if (win == 0) begin
      m_addr = ha; m_wd = hd; rd = !hw; wr = hw;
    end else if (win == 1) begin
      m_addr = ea; m_wd = ed; rd = !ew; wr = ew;
    end
    if (win >= 0) begin
      m_last_eng = (win == 1);
      if (wr) shadow[m_addr] = m_wd;
      else begin
        r.due = cyc + 2; r.eng = (win == 1);
        r.data = shadow[m_addr];
        pend.push_back(r);
      end
    end
    m_hg = (win == 0);
    m_eg = (win == 1);
    hv = 0; ev = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.eng) begin ev = 1; m_erd = r.data; end
      else begin hv = 1; m_hrd = r.data; end
    end
    chk("h_gnt", 32'(h_gnt), 32'(m_hg));
    chk("e_gnt", 32'(e_gnt), 32'(m_eg));
    chk("rf_en_read", 32'(rf_en_read), 32'(rd));
    chk("rf_en_write", 32'(rf_en_write), 32'(wr));
    chk("rf_address", 32'(rf_address), 32'(m_addr));
    chk("rf_data_in", 32'(rf_data_in), 32'(m_wd));
    chk("h_rvalid", 32'(h_rvalid), 32'(hv));
    chk("e_rvalid", 32'(e_rvalid), 32'(ev));
    chk("h_rdata", 32'(h_rdata), 32'(m_hrd));
    chk("e_rdata", 32'(e_rdata), 32'(m_erd));
    chk("engine_run", 32'(engine_run), 32'(ct));
    if (m_hg && h_act) begin void'(hq.pop_front()); h_act = 0; end
    if (m_eg && e_act) begin void'(eq.pop_front()); e_act = 0; end
    if (!h_act && hq.size() > 0) begin
      if (h_wait < hq[0].gap) h_wait++;
      else begin h_act = 1; h_wait = 0; end
    end
    if (!e_act && eq.size() > 0) begin
      if (e_wait < eq[0].gap) e_wait++;
      else begin e_act = 1; e_wait = 0; end
    end
    if (h_act) begin
      h_req = 1; h_we = hq[0].we; h_addr = hq[0].addr;
      h_wdata = hq[0].data; h_lock = hq[0].lock;
    end else begin
      h_req = 0; h_lock = 0;
    end
    if (e_act) begin
      e_req = 1; e_we = eq[0].we; e_addr = eq[0].addr;
      e_wdata = eq[0].data;
    end else begin
      e_req = 0;
    end
  endtask

  task automatic drain(string tag, int limit);
    int n;
    n = 0;
    while ((hq.size() + eq.size() + pend.size()) > 0 && n < limit) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(hq.size() + eq.size() + pend.size()), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 0;
    h_we = 0; h_addr = '0; h_wdata = '0;
    e_we = 0; e_addr = '0; e_wdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check_zero("reset");
    @(negedge clock) rst_n = 1;

    // host write then read back
    cmd(hq, 1, 12'h005, 24'hABCDEF, 0, 0);
    cmd(hq, 0, 12'h005, 24'h0, 0, 0);
    drain("wr_rd", 50);
    chk("h_rdata_005", 32'(h_rdata), 32'h00ABCDEF);

    // preload then contention
    cmd(hq, 1, 12'h010, 24'h000111, 0, 0);
    cmd(eq, 1, 12'h020, 24'h000222, 0, 0);
    drain("preload", 50);
    for (int i = 0; i < 3; i++) begin
      cmd(hq, 0, 12'h010, 24'h0, 0, 0);
      cmd(eq, 0, 12'h020, 24'h0, 0, 0);
    end
    drain("contend", 50);
    chk("h_rdata_010", 32'(h_rdata), 32'h00000111);
    chk("e_rdata_020", 32'(e_rdata), 32'h00000222);

    // locked read-modify-write of the control register
    cmd(hq, 0, 12'h000, 24'h0, 1, 0);
    cmd(hq, 1, 12'h000, 24'h000001, 1, 0);
    cmd(eq, 0, 12'h020, 24'h0, 0, 1);
    drain("lock", 50);
    chk("engine_run_set", 32'(engine_run), 1);

    // single requester holding its request
    for (int i = 0; i < 4; i++) cmd(eq, 0, 12'h005, 24'h0, 0, 0);
    drain("single", 50);
    chk("e_rdata_005", 32'(e_rdata), 32'h00ABCDEF);

    // idle
    repeat (5) step();
    chk("h_rdata_known", 32'($isunknown(h_rdata)), 0);
    chk("e_rdata_known", 32'($isunknown(e_rdata)), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cmd(hq, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
          24'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 3));
      cmd(eq, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
          24'($urandom), 0, $urandom_range(0, 3));
    end
    drain("random", 20000);

    // reset during a host read's grant cycle
    cmd(hq, 0, 12'h005, 24'h0, 0, 0);
    n = 0;
    while (!m_hg && n < 20) begin step(); n++; end
    chk("mid_read_gnt", 32'(h_gnt), 1);
    #3 rst_n = 0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clock);
    @(negedge clock) rst_n = 1;
    repeat (4) step();
    // first tie after reset goes to the host
    cmd(hq, 0, 12'h005, 24'h0, 0, 0);
    cmd(eq, 0, 12'h010, 24'h0, 0, 0);
    step();
    step();
    chk("tie_host_first", 32'(h_gnt), 1);
    drain("post_rst", 50);
    chk("post_rst_e_rdata", 32'(e_rdata), 32'h00000111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
